multicycle_adder: RTL and testbench

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

---
 rtl/multicycle_adder_if.sv | 26 ++
 rtl/multicycle_adder.sv | 126 ++++++++++++
 tb/tb_multicycle_adder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_adder_if.sv
// Request/result bundle for the multicycle adder.
// The master drives the operation request and the slave returns the result and status.
interface multicycle_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, a, b, cin,
    input  s, cout, ovf, busy, done
  );

  modport slave (
    input  start, mode, a, b, cin,
    output s, cout, ovf, busy, done
  );
endinterface

// File: rtl/multicycle_adder.sv
// Add/subtract unit that ripples CHUNK bits per cycle through a WIDTH-bit operand pair.
// Each result takes NCH = WIDTH/CHUNK RUN cycles, and a one-cycle done pulse follows.
module multicycle_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_adder_if.slave  bus
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]    LAST       = CW'(NCH - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_eff_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic [31:0]      shamt_s;
  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK:0]   sum_s;
  logic [WIDTH-1:0] s_next_s;
  logic             ovf_next_s;
  logic             accept_s;
  logic             last_s;

  function automatic logic [CHUNK:0] chunk_add(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             c
  );
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  // Datapath for the chunk selected by count_r, plus the merged result word.
  always_comb begin
    shamt_s    = 32'(count_r) * 32'(CHUNK);
    a_chunk_s  = CHUNK'(a_r >> shamt_s);
    b_chunk_s  = CHUNK'(b_eff_r >> shamt_s);
    sum_s      = chunk_add(a_chunk_s, b_chunk_s, carry_r);
    s_next_s   = (s_r & ~(CHUNK_MASK << shamt_s)) | (WIDTH'(sum_s[CHUNK-1:0]) << shamt_s);
    // Only meaningful on the last chunk, where sum_s holds the result MSB.
    ovf_next_s = (a_r[WIDTH-1] == b_eff_r[WIDTH-1]) && (sum_s[CHUNK-1] != a_r[WIDTH-1]);
    accept_s   = bus.start && (state_r != RUN);
    last_s     = (count_r == LAST);
  end

  // Control FSM, operand capture and the registered result and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_eff_r <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      count_r <= {CW{1'b0}};
      s_r     <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (accept_s) begin
      // Subtraction is A + ~B + 1, so only the inverted B and the forced carry need to be kept.
      a_r     <= bus.a;
      b_eff_r <= bus.mode ? ~bus.b : bus.b;
      carry_r <= bus.mode ? 1'b1 : bus.cin;
      count_r <= {CW{1'b0}};
      state_r <= RUN;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        RUN: begin
          s_r     <= s_next_s;
          carry_r <= sum_s[CHUNK];
          if (last_s) begin
            count_r <= {CW{1'b0}};
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            cout_r  <= sum_s[CHUNK];
            ovf_r   <= ovf_next_s;
          end else begin
            count_r <= count_r + CW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s    = s_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder with WIDTH=32 and CHUNK=8.
// Expected values are hand-computed, and each comparison is an immediate assertion.
module tb_multicycle_adder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   bcnt;
  int   dcnt;

  multicycle_adder_if #(.WIDTH(32)) bus ();

  multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic request(input logic m, input logic [31:0] av, input logic [31:0] bv, input logic c);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = c;
  endtask

  // Called just after the accepting edge; lat counts the edges until done is seen.
  task automatic wait_done(output int l, output int bc);
    l  = 0;
    bc = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && l < 20) begin
      tick();
      l++;
      if (bus.busy === 1'b1) bc++;
    end
  endtask

  task automatic count_done(input int n, output int d);
    d = 0;
    repeat (n) begin
      tick();
      if (bus.done === 1'b1) d++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    bus.cin   = 1'b0;
    tick();
    tick();
    check32("reset_s", bus.s, 32'h0);
    check1("reset_cout", bus.cout, 1'b0);
    check1("reset_ovf", bus.ovf, 1'b0);
    check1("reset_busy", bus.busy, 1'b0);
    check1("reset_done", bus.done, 1'b0);
    rst = 1'b0;
    tick();

    // FFFFFFFF + 1: carries ripple through every chunk.
    request(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    check32("add_wrap_latency", 32'(lat), 32'd4);
    check32("add_wrap_busy_cycles", 32'(bcnt), 32'd4);
    check32("add_wrap_s", bus.s, 32'h0000_0000);
    check1("add_wrap_cout", bus.cout, 1'b1);
    check1("add_wrap_ovf", bus.ovf, 1'b0);
    tick();
    check1("done_one_cycle", bus.done, 1'b0);

    // 7FFFFFFF + 1: signed overflow.
    request(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    check32("add_ovf_latency", 32'(lat), 32'd4);
    check32("add_ovf_s", bus.s, 32'h8000_0000);
    check1("add_ovf_cout", bus.cout, 1'b0);
    check1("add_ovf_ovf", bus.ovf, 1'b1);
    tick();
    tick();
    check32("idle_hold_s", bus.s, 32'h8000_0000);
    check1("idle_hold_ovf", bus.ovf, 1'b1);
    check1("idle_busy", bus.busy, 1'b0);
    check1("idle_done", bus.done, 1'b0);

    // 5 - 7 with cin=1, which must be ignored.
    request(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1);
    tick();
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    check32("sub_s", bus.s, 32'hFFFF_FFFE);
    check1("sub_cout", bus.cout, 1'b0);
    check1("sub_ovf", bus.ovf, 1'b0);

    // Back-to-back start issued during the DONE cycle.
    request(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);
    tick();
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    check32("b2b_done_spacing", 32'(lat + 1), 32'd5);
    check32("b2b_s", bus.s, 32'h2345_678A);
    check1("b2b_cout", bus.cout, 1'b0);
    check1("b2b_ovf", bus.ovf, 1'b0);
    tick();

    // Reset two cycles after accepting: outputs clear at once and no done follows.
    request(1'b0, 32'hAAAA_0000, 32'h0000_1111, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check32("async_rst_s", bus.s, 32'h0);
    check1("async_rst_busy", bus.busy, 1'b0);
    check1("async_rst_done", bus.done, 1'b0);
    check1("async_rst_cout", bus.cout, 1'b0);
    check1("async_rst_ovf", bus.ovf, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_done(8, dcnt);
    check32("abort_no_done", 32'(dcnt), 32'd0);
    request(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0);
    tick();
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    check32("post_rst_latency", 32'(lat), 32'd4);
    check32("post_rst_s", bus.s, 32'h0000_0007);

    // Start plus new operands while busy must not disturb the operation in flight.
    tick();
    request(1'b0, 32'h0000_0100, 32'h0000_0200, 1'b0);
    tick();
    request(1'b1, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1);
    tick();
    bus.start = 1'b0;
    bus.a     = 32'h1357_9BDF;
    bus.b     = 32'h2468_ACE0;
    wait_done(lat, bcnt);
    check32("busy_start_latency", 32'(lat), 32'd3);
    check32("busy_start_s", bus.s, 32'h0000_0300);
    check1("busy_start_cout", bus.cout, 1'b0);
    count_done(6, dcnt);
    check32("busy_start_no_extra_done", 32'(dcnt), 32'd0);
    check1("busy_start_idle", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
